// File: rtl/frame_capture.sv
// Captures one filtered frame into on-chip RAM and serves host reads.
// Registered read port returns pre-write data on same-address collisions.
module frame_capture #(
  parameter  int W     = 5,
  parameter  int H     = 5,
  localparam int OW    = W - 2,
  localparam int OH    = H - 2,
  localparam int DEPTH = OW * OH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_in_valid,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow,
  output logic [15:0]   pix_count
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic [7:0]    mem [DEPTH];
  logic          we;
  logic          last;
  logic          rd_in_range;

  assign we          = (state == CAPTURE) && pix_in_valid;
  assign last        = (wr_addr == AW'(DEPTH - 1));
  assign rd_in_range = (32'(rd_addr) < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      pix_count  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CAPTURE;
            busy      <= 1'b1;
            wr_addr   <= '0;
            pix_count <= '0;
          end
        end
        CAPTURE: begin
          if (pix_in_valid) begin
            pix_count <= pix_count + 16'd1;
            if (last) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              wr_addr    <= '0;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end
        DONE: begin
          // a restart wins over a coincident stray pixel
          if (start) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            wr_addr    <= '0;
            pix_count  <= '0;
          end else if (pix_in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : 8'h00;
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture at W=H=5 (nine stored pixels).
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_in_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       frame_done;
  logic       overflow;
  logic [15:0] pix_count;

  int n_chk = 0;
  int n_fail = 0;

  frame_capture #(.W(5), .H(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pix_in(pix_in),
    .pix_in_valid(pix_in_valid),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_rdv"}, int'(rd_valid), 0);
    chk({tag, "_rdd"}, int'(rd_data), 0);
    chk({tag, "_cnt"}, int'(pix_count), 0);
  endtask

  task automatic read_all(input string tag, input int base);
    for (int a = 0; a < 9; a++) begin
      rd_en = 1'b1;
      rd_addr = 4'(a);
      step();
      chk($sformatf("%s_rd%0d", tag, a), int'(rd_data), base + a);
      chk($sformatf("%s_rv%0d", tag, a), int'(rd_valid), 1);
    end
    rd_en = 1'b0;
  endtask

  task automatic stream(input string tag, input int base, input bit gap);
    for (int i = 0; i < 9; i++) begin
      pix_in = 8'(base + i);
      pix_in_valid = 1'b1;
      step();
      chk($sformatf("%s_cnt%0d", tag, i), int'(pix_count), i + 1);
      chk($sformatf("%s_busy%0d", tag, i), int'(busy), (i < 8) ? 1 : 0);
      chk($sformatf("%s_done%0d", tag, i), int'(frame_done), (i < 8) ? 0 : 1);
      pix_in_valid = 1'b0;
      if (gap && i < 8) begin
        step();
        chk($sformatf("%s_gcnt%0d", tag, i), int'(pix_count), i + 1);
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_rst("reset");
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // stray pixels before and together with start
    pix_in = 8'h55;
    pix_in_valid = 1'b1;
    step();
    step();
    chk("idle_cnt", int'(pix_count), 0);
    chk("idle_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    pix_in_valid = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_cnt", int'(pix_count), 0);
    step();
    chk("cap_cnt0", int'(pix_count), 0);

    stream("s1", 10, 1'b0);
    read_all("r1", 10);
    step();
    chk("hold_rdv", int'(rd_valid), 0);
    chk("hold_rdd", int'(rd_data), 18);

    rd_en = 1'b1;
    rd_addr = 4'd9;
    step();
    rd_en = 1'b0;
    chk("oob_rdd", int'(rd_data), 0);
    chk("oob_rdv", int'(rd_valid), 1);

    // overflow in DONE
    pix_in = 8'hAA;
    pix_in_valid = 1'b1;
    step();
    pix_in_valid = 1'b0;
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_done", int'(frame_done), 1);
    step();
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_cnt", int'(pix_count), 9);
    read_all("r2", 10);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_ovf", int'(overflow), 0);
    chk("rs_done", int'(frame_done), 0);
    chk("rs_busy", int'(busy), 1);
    chk("rs_cnt", int'(pix_count), 0);

    // gapped stream; read addr 3 while pixel 23 is written there
    for (int i = 0; i < 3; i++) begin
      pix_in = 8'(20 + i);
      pix_in_valid = 1'b1;
      step();
      pix_in_valid = 1'b0;
      step();
    end
    pix_in = 8'd23;
    pix_in_valid = 1'b1;
    rd_en = 1'b1;
    rd_addr = 4'd3;
    step();
    pix_in_valid = 1'b0;
    rd_en = 1'b0;
    chk("col_rdd", int'(rd_data), 13);
    chk("col_cnt", int'(pix_count), 4);
    step();
    for (int i = 4; i < 9; i++) begin
      pix_in = 8'(20 + i);
      pix_in_valid = 1'b1;
      step();
      pix_in_valid = 1'b0;
      chk($sformatf("g_busy%0d", i), int'(busy), (i < 8) ? 1 : 0);
      chk($sformatf("g_done%0d", i), int'(frame_done), (i < 8) ? 0 : 1);
      if (i < 8) step();
    end
    chk("g_cnt", int'(pix_count), 9);
    read_all("r3", 20);

    // reset mid-capture
    start = 1'b1;
    step();
    start = 1'b0;
    stream_partial();
    #2 rst_n = 1'b0;
    #1 chk_rst("mid");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_start", int'(busy), 1);
    stream("s4", 1, 1'b0);
    read_all("r4", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic stream_partial();
    for (int i = 0; i < 4; i++) begin
      pix_in = 8'(40 + i);
      pix_in_valid = 1'b1;
      step();
    end
    pix_in_valid = 1'b0;
    chk("part_cnt", int'(pix_count), 4);
    chk("part_busy", int'(busy), 1);
  endtask

endmodule
